ms_fifo_rr: RTL and testbench

- Multi-stream FIFO, successor to the two-flux tagged FIFO. One shared write port; the channel tag is taken from the data MSBs.
- FLUX independent circular queues, each DEPTH deep, with per-channel occupancy counters and a sticky overflow flag.
- A round-robin read arbiter pops at most one channel per cycle. Output data is registered and carries valid and channel-id qualifiers.
- Sits between the dataflow crossbar output and the per-actor input stages.

---
 rtl/ms_fifo_pkg.sv | 45 ++++
 rtl/ms_fifo_rr_arbiter.sv | 36 +++
 rtl/ms_fifo_rr.sv | 144 ++++++++++++++
 tb/tb_ms_fifo_rr.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_fifo_pkg.sv
// Shared helpers for the multi-stream FIFO family: width derivation,
// tag extraction and the rotate-priority one-hot search.
package ms_fifo_pkg;

    localparam int unsigned MAX_N = 32;

    function automatic int unsigned tag_width_f(input int unsigned flux);
        return (flux > 32'd1) ? $clog2(flux) : 32'd1;
    endfunction

    function automatic int unsigned cnt_width_f(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

    function automatic int unsigned tag_of(input logic [63:0] data,
                                           input int unsigned width,
                                           input int unsigned tw);
        logic [63:0] sh;
        sh = data >> (width - tw);
        return 32'(sh & ((64'd1 << tw) - 64'd1));
    endfunction

    // First set request at or above ptr, wrapping modulo n.
    function automatic logic [MAX_N-1:0] rr_onehot(input logic [MAX_N-1:0] req,
                                                   input int unsigned ptr,
                                                   input int unsigned n);
        logic [MAX_N-1:0] g;
        logic             found;
        int unsigned      idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < MAX_N; j++) begin
            idx = ptr + j;
            idx = (idx >= n) ? idx - n : idx;
            if ((j < n) && !found && req[idx[4:0]]) begin
                g[idx[4:0]] = 1'b1;
                found       = 1'b1;
            end else begin
                found = found;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/ms_fifo_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module rr_arbiter
    import ms_fifo_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         ck,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rr_ptr_r;
    logic [PW-1:0] ptr_nxt_s;

    // Grant decode and next pointer
    always_comb begin
        gnt       = N'(rr_onehot(MAX_N'(req), 32'(rr_ptr_r), N));
        ptr_nxt_s = rr_ptr_r;
        for (int k = 0; k < N; k++) begin
            ptr_nxt_s = gnt[k] ? ((k == N - 1) ? '0 : PW'(k + 1)) : ptr_nxt_s;
        end
    end

    // Pointer register
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= '0;
        end else begin
            rr_ptr_r <= ptr_nxt_s;
        end
    end

endmodule

// File: rtl/ms_fifo_rr.sv
// Multi-stream tagged FIFO with round-robin read arbitration.
// Optional almost_full output enabled by defining MS_FIFO_ALMOST_EN.
module ms_fifo_rr
    import ms_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int FLUX  = 2,
`ifdef MS_FIFO_ALMOST_EN
    parameter int AF_LEVEL = DEPTH - 1,
`endif
    localparam int TAG_WIDTH = tag_width_f(FLUX),
    localparam int CNT_WIDTH = cnt_width_f(DEPTH)
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic                      wr,
    input  logic [WIDTH-1:0]          datain,
    input  logic [FLUX-1:0]           rd,
    output logic [FLUX-1:0]           gnt,
    output logic [FLUX-1:0]           full,
    output logic [FLUX-1:0]           empty,
    output logic [FLUX*CNT_WIDTH-1:0] count,
    output logic [FLUX-1:0]           ovf,
    output logic [WIDTH-1:0]          dataout,
    output logic                      dout_valid,
`ifdef MS_FIFO_ALMOST_EN
    output logic [FLUX-1:0]           almost_full,
`endif
    output logic [TAG_WIDTH-1:0]      dout_ch
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem_r [FLUX][DEPTH];
    logic [PW-1:0]        wp_r  [FLUX];
    logic [PW-1:0]        rp_r  [FLUX];
    logic [CNT_WIDTH-1:0] cnt_r [FLUX];
    logic [FLUX-1:0]      ovf_r;
    logic [FLUX-1:0]      wacc_s;
    logic [FLUX-1:0]      wrej_s;
    logic [FLUX-1:0]      req_s;
    logic [TAG_WIDTH-1:0] gidx_s;
    int unsigned          tag_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flag decode from registered occupancy
    always_comb begin
        for (int i = 0; i < FLUX; i++) begin
            full[i]  = (cnt_r[i] == CNT_WIDTH'(DEPTH));
            empty[i] = (cnt_r[i] == '0);
            count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_r[i];
        end
        ovf = ovf_r;
    end

`ifdef MS_FIFO_ALMOST_EN
    // Almost-full decode
    always_comb begin
        for (int i = 0; i < FLUX; i++) begin
            almost_full[i] = (cnt_r[i] >= CNT_WIDTH'(AF_LEVEL));
        end
    end
`endif

    // Write accept/reject per channel; out-of-range tags match nothing
    always_comb begin
        tag_s  = tag_of(64'(datain), WIDTH, TAG_WIDTH);
        wacc_s = '0;
        wrej_s = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (wr && (tag_s == 32'(i))) begin
                wacc_s[i] = ~full[i];
                wrej_s[i] = full[i];
            end else begin
                wacc_s[i] = 1'b0;
                wrej_s[i] = 1'b0;
            end
        end
    end

    // Eligible requests and granted channel index
    always_comb begin
        req_s  = rd & ~empty;
        gidx_s = '0;
        for (int i = 0; i < FLUX; i++) begin
            gidx_s = gnt[i] ? TAG_WIDTH'(i) : gidx_s;
        end
    end

    rr_arbiter #(.N(FLUX)) u_arb (
        .ck  (ck),
        .rst (rst),
        .req (req_s),
        .gnt (gnt)
    );

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FLUX; i++) begin
                wp_r[i]  <= '0;
                rp_r[i]  <= '0;
                cnt_r[i] <= '0;
            end
            ovf_r <= '0;
        end else begin
            for (int i = 0; i < FLUX; i++) begin
                wp_r[i]  <= wacc_s[i] ? ptr_inc(wp_r[i]) : wp_r[i];
                rp_r[i]  <= gnt[i] ? ptr_inc(rp_r[i]) : rp_r[i];
                cnt_r[i] <= cnt_r[i] + CNT_WIDTH'(wacc_s[i]) - CNT_WIDTH'(gnt[i]);
            end
            ovf_r <= ovf_r | wrej_s;
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge ck) begin
        for (int i = 0; i < FLUX; i++) begin
            if (wacc_s[i]) begin
                mem_r[i][wp_r[i]] <= datain;
            end
        end
    end

    // Registered read port
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            dataout    <= '0;
            dout_valid <= 1'b0;
            dout_ch    <= '0;
        end else if (|gnt) begin
            dataout    <= mem_r[gidx_s][rp_r[gidx_s]];
            dout_valid <= 1'b1;
            dout_ch    <= gidx_s;
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ms_fifo_rr.sv
// Bench for ms_fifo_rr: two configurations (8/4/2 and 8/5/3) checked against queue models.
module tb_ms_fifo_rr;

    logic ck = 1'b0;
    always #5 ck = ~ck;
    logic rst;

    logic       wr0;   logic [7:0] datain0; logic [1:0] rd0;
    logic [1:0] gnt0, full0, empty0, ovf0;  logic [5:0] count0;
    logic [7:0] dataout0; logic dout_valid0; logic [0:0] dout_ch0;
    logic       wr1;   logic [7:0] datain1; logic [2:0] rd1;
    logic [2:0] gnt1, full1, empty1, ovf1;  logic [8:0] count1;
    logic [7:0] dataout1; logic dout_valid1; logic [1:0] dout_ch1;
`ifdef MS_FIFO_ALMOST_EN
    logic [1:0] almost_full0; logic [2:0] almost_full1;
`endif

    ms_fifo_rr #(.WIDTH(8), .DEPTH(4), .FLUX(2)) u0 (
        .ck(ck), .rst(rst), .wr(wr0), .datain(datain0), .rd(rd0), .gnt(gnt0),
        .full(full0), .empty(empty0), .count(count0), .ovf(ovf0), .dataout(dataout0),
        .dout_valid(dout_valid0),
`ifdef MS_FIFO_ALMOST_EN
        .almost_full(almost_full0),
`endif
        .dout_ch(dout_ch0));

    ms_fifo_rr #(.WIDTH(8), .DEPTH(5), .FLUX(3)) u1 (
        .ck(ck), .rst(rst), .wr(wr1), .datain(datain1), .rd(rd1), .gnt(gnt1),
        .full(full1), .empty(empty1), .count(count1), .ovf(ovf1), .dataout(dataout1),
        .dout_valid(dout_valid1),
`ifdef MS_FIFO_ALMOST_EN
        .almost_full(almost_full1),
`endif
        .dout_ch(dout_ch1));

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: one queue per (dut, channel), index m*3+ch
    logic [7:0] q [6][$];
    logic       ovf_m [6];
    int         rr_m  [2];
    logic       dv_m  [2];
    logic [7:0] do_m  [2];
    int         ch_m  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nch_of(int m);   return (m == 0) ? 2 : 3; endfunction
    function automatic int depth_of(int m); return (m == 0) ? 4 : 5; endfunction
    function automatic int tw_of(int m);    return (m == 0) ? 1 : 2; endfunction

    function automatic logic [2:0] exp_gnt(int m, logic [2:0] r);
        int n = nch_of(m);
        for (int j = 0; j < n; j++) begin
            int c = (rr_m[m] + j) % n;
            if (r[c] && q[m*3+c].size() > 0) return 3'(1 << c);
        end
        return 3'b000;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 6; i++) begin
            q[i].delete();
            ovf_m[i] = 1'b0;
        end
        for (int m = 0; m < 2; m++) begin
            rr_m[m] = 0; dv_m[m] = 1'b0; do_m[m] = 8'h00; ch_m[m] = 0;
        end
    endtask

    task automatic compare(int m);
        logic [2:0] a_gnt, a_full, a_empty, a_ovf, r, e_full, e_empty, e_ovf, a_af, e_af;
        logic [8:0] a_cnt, e_cnt;
        logic       a_dv;
        logic [7:0] a_do;
        logic [1:0] a_ch;
        int         n = nch_of(m);
        if (m == 0) begin
            a_gnt = {1'b0, gnt0}; a_full = {1'b0, full0}; a_empty = {1'b0, empty0};
            a_ovf = {1'b0, ovf0}; a_cnt = {3'b000, count0}; a_dv = dout_valid0;
            a_do = dataout0; a_ch = {1'b0, dout_ch0}; r = {1'b0, rd0}; a_af = 3'b000;
`ifdef MS_FIFO_ALMOST_EN
            a_af = {1'b0, almost_full0};
`endif
        end else begin
            a_gnt = gnt1; a_full = full1; a_empty = empty1; a_ovf = ovf1; a_cnt = count1;
            a_dv = dout_valid1; a_do = dataout1; a_ch = dout_ch1; r = rd1; a_af = 3'b000;
`ifdef MS_FIFO_ALMOST_EN
            a_af = almost_full1;
`endif
        end
        e_cnt = '0; e_full = '0; e_empty = '0; e_ovf = '0; e_af = '0;
        for (int c = 0; c < n; c++) begin
            int sz = q[m*3+c].size();
            e_cnt[c*3 +: 3] = 3'(sz);
            e_full[c]  = (sz == depth_of(m));
            e_empty[c] = (sz == 0);
            e_ovf[c]   = ovf_m[m*3+c];
            e_af[c]    = (sz >= depth_of(m) - 1);
        end
        chk($sformatf("d%0d gnt", m),        32'(a_gnt),   32'(exp_gnt(m, r)));
        chk($sformatf("d%0d count", m),      32'(a_cnt),   32'(e_cnt));
        chk($sformatf("d%0d full", m),       32'(a_full),  32'(e_full));
        chk($sformatf("d%0d empty", m),      32'(a_empty), 32'(e_empty));
        chk($sformatf("d%0d ovf", m),        32'(a_ovf),   32'(e_ovf));
        chk($sformatf("d%0d dout_valid", m), 32'(a_dv),    32'(dv_m[m]));
        chk($sformatf("d%0d dataout", m),    32'(a_do),    32'(do_m[m]));
        if (dv_m[m]) chk($sformatf("d%0d dout_ch", m), 32'(a_ch), 32'(ch_m[m]));
`ifdef MS_FIFO_ALMOST_EN
        chk($sformatf("d%0d almost_full", m), 32'(a_af), 32'(e_af));
`else
        if (a_af != e_af) begin end
`endif
    endtask

    task automatic update(int m, logic w, logic [7:0] d, logic [2:0] r);
        int         n   = nch_of(m);
        int         tag = int'(d >> (8 - tw_of(m)));
        logic [2:0] g   = exp_gnt(m, r);
        logic       wfull = (tag < n) && (q[m*3+tag].size() == depth_of(m));
        dv_m[m] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (g[k]) begin
                do_m[m] = q[m*3+k].pop_front();
                dv_m[m] = 1'b1;
                ch_m[m] = k;
                rr_m[m] = (k + 1) % n;
            end
        end
        if (w && tag < n) begin
            if (wfull) ovf_m[m*3+tag] = 1'b1;
            else       q[m*3+tag].push_back(d);
        end
    endtask

    task automatic cycle(input logic w0, input logic [7:0] d0, input logic [1:0] r0,
                         input logic w1, input logic [7:0] d1, input logic [2:0] r1);
        @(negedge ck);
        wr0 = w0; datain0 = d0; rd0 = r0;
        wr1 = w1; datain1 = d1; rd1 = r1;
        #1;
        compare(0);
        compare(1);
        update(0, w0, d0, {1'b0, r0});
        update(1, w1, d1, r1);
    endtask

    task automatic c0(input logic w, input logic [7:0] d, input logic [1:0] r);
        cycle(w, d, r, 1'b0, 8'h00, 3'b000);
    endtask

    task automatic c1(input logic w, input logic [7:0] d, input logic [2:0] r);
        cycle(1'b0, 8'h00, 2'b00, w, d, r);
    endtask

    task automatic settle();
        @(posedge ck);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        wr0 = 1'b0; datain0 = 8'h00; rd0 = 2'b00;
        wr1 = 1'b0; datain1 = 8'h00; rd1 = 3'b000;
        reset_model();
        #12;
        chk("reset empty0", 32'(empty0), 32'h3);
        chk("reset full0", 32'(full0), 32'h0);
        chk("reset count0", 32'(count0), 32'h0);
        chk("reset dout_valid0", 32'(dout_valid0), 32'h0);
        compare(0);
        compare(1);
        @(negedge ck);
        rst = 1'b1;

        // Channel 1 fill, overflow and in-order drain
        for (int i = 0; i < 4; i++) c0(1'b1, 8'(8'h81 + i), 2'b00);
        settle();
        chk("t2 full1", 32'(full0[1]), 32'h1);
        chk("t2 count1", 32'(count0[5:3]), 32'h4);
        c0(1'b1, 8'h85, 2'b00);
        settle();
        chk("t2 ovf1", 32'(ovf0[1]), 32'h1);
        chk("t2 count1 after drop", 32'(count0[5:3]), 32'h4);
        for (int i = 0; i < 4; i++) begin
            c0(1'b0, 8'h00, 2'b10);
            settle();
            chk("t2 dataout", 32'(dataout0), 32'(8'h81 + i));
            chk("t2 dout_ch", 32'(dout_ch0), 32'h1);
        end

        // Round-robin fairness with both channels requesting
        for (int i = 0; i < 3; i++) begin
            c0(1'b1, 8'(8'h10 + i), 2'b00);
            c0(1'b1, 8'(8'hA0 + i), 2'b00);
        end
        for (int i = 0; i < 7; i++) begin
            c0(1'b0, 8'h00, 2'b11);
            if (i < 6) chk("t3 gnt", 32'(gnt0), (i % 2 == 0) ? 32'h1 : 32'h2);
            else       chk("t3 gnt idle", 32'(gnt0), 32'h0);
            if (i > 0) begin
                chk("t3 dout_valid", 32'(dout_valid0), 32'h1);
                chk("t3 dout_ch", 32'(dout_ch0), 32'((i - 1) % 2));
            end
        end

        // Same-cycle write/read on full and on empty channels
        for (int i = 0; i < 4; i++) c0(1'b1, 8'(8'h01 + i), 2'b00);
        c0(1'b1, 8'h0A, 2'b01);
        settle();
        chk("t4 ovf0", 32'(ovf0[0]), 32'h1);
        chk("t4 count0", 32'(count0[2:0]), 32'h3);
        c0(1'b1, 8'h90, 2'b10);
        chk("t4 gnt empty", 32'(gnt0), 32'h0);
        settle();
        chk("t4 count1", 32'(count0[5:3]), 32'h1);
        c0(1'b0, 8'h00, 2'b10);
        settle();
        chk("t4 dataout", 32'(dataout0), 32'h90);

        // Non-power-of-two config: stream through ch2, wrap, overflow, bad tag
        for (int i = 0; i < 12; i++) c1(1'b1, 8'(8'h80 + i), (i >= 2) ? 3'b100 : 3'b000);
        for (int i = 0; i < 3; i++) c1(1'b1, 8'(8'h8C + i), 3'b000);
        settle();
        chk("t5 count2 full", 32'(count1[8:6]), 32'h5);
        chk("t5 full2", 32'(full1[2]), 32'h1);
        c1(1'b1, 8'h9F, 3'b000);
        settle();
        chk("t5 ovf2", 32'(ovf1[2]), 32'h1);
        c1(1'b1, 8'hC5, 3'b000);
        settle();
        chk("t5 bad tag count", 32'(count1), 32'h140);
        for (int i = 0; i < 5; i++) begin
            c1(1'b0, 8'h00, 3'b100);
            settle();
            chk("t5 dataout", 32'(dataout1), 32'(8'h8A + i));
        end

`ifdef MS_FIFO_ALMOST_EN
        // Almost-full threshold on dut0 ch0 (currently holds 3 entries)
        for (int i = 0; i < 3; i++) c0(1'b0, 8'h00, 2'b01);
        c0(1'b1, 8'h21, 2'b00); c0(1'b1, 8'h22, 2'b00);
        settle();
        chk("t6 af after 2", 32'(almost_full0[0]), 32'h0);
        c0(1'b1, 8'h23, 2'b00);
        settle();
        chk("t6 af after 3", 32'(almost_full0[0]), 32'h1);
        c0(1'b0, 8'h00, 2'b01);
        settle();
        chk("t6 af after read", 32'(almost_full0[0]), 32'h0);
`endif

        // Randomised traffic on both configurations
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 3) != 0, 8'($urandom), 2'($urandom),
                  ($urandom % 3) != 0, 8'($urandom), 3'($urandom));
        end

        // Asynchronous reset mid-stream
        @(negedge ck);
        #2;
        rst = 1'b0;
        wr0 = 1'b0; rd0 = 2'b00; wr1 = 1'b0; rd1 = 3'b000;
        #1;
        chk("mid reset count0", 32'(count0), 32'h0);
        chk("mid reset empty0", 32'(empty0), 32'h3);
        chk("mid reset ovf0", 32'(ovf0), 32'h0);
        chk("mid reset dout_valid0", 32'(dout_valid0), 32'h0);
        chk("mid reset dataout0", 32'(dataout0), 32'h0);
        reset_model();
        compare(0);
        compare(1);
        @(negedge ck);
        rst = 1'b1;

        for (int i = 0; i < 500; i++) begin
            cycle(($urandom % 2) != 0, 8'($urandom), 2'($urandom),
                  ($urandom % 2) != 0, 8'($urandom), 3'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
